// File: rtl/tt_divider_pkg.sv
// Shared constants for the 8-bit restoring divider: FSM encoding and uio pin map.
package tt_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // uio_in control bits
  localparam int UIO_START = 0;
  localparam int UIO_LOAD  = 1;
  localparam int UIO_LSEL  = 2;
  localparam int UIO_OSEL  = 3;

  // uio_out status bits
  localparam int UIO_BUSY  = 4;
  localparam int UIO_DONE  = 5;
  localparam int UIO_DBZ   = 6;

  // Upper nibble drives status, lower nibble receives control
  localparam logic [7:0] UIO_OE_VAL = 8'b1111_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor if it fits, and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvsr_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;

  // Trial subtraction; when it fits the true difference is < divisor, so the
  // low WIDTH bits of a modular subtract are exact.
  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {1'b0, dvsr_i});
    rem_o = q_o ? (trial[WIDTH-1:0] - dvsr_i) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/tt_um_ashergitscrazy_divider.sv
// Tiny Tapeout wrapper: 8-bit unsigned restoring divider, one quotient bit
// per enabled clock, with operand load and edge-triggered start.
module tt_um_ashergitscrazy_divider
  import tt_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [7:0]       uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic             edge_q, edge_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [CW-1:0]    bit_idx;
  logic             unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:4]};
  assign bit_idx    = CW'(WIDTH - 1) - cnt_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .dvsr_i (dvsr_q),
    .bit_i  (dvd_q[bit_idx]),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  // Next-state: start edge detect, operand loads, FSM and iteration datapath
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    start_d = uio_in[UIO_START];
    // Edges seen while busy are dropped so they cannot fire after RUN ends
    edge_d  = uio_in[UIO_START] & ~start_q & (state_q != S_RUN);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (uio_in[UIO_LOAD]) begin
          if (uio_in[UIO_LSEL]) dvsr_d = ui_in;
          else                  dvd_d  = ui_in;
        end
        if (edge_q) begin
          if (dvsr_q == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = dvd_q;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            quo_d   = '0;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; ena=0 freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      edge_q  <= 1'b0;
      dvd_q   <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      start_q <= start_d;
      edge_q  <= edge_d;
      dvd_q   <= dvd_d;
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Output mux and status pins
  always_comb begin
    uo_out            = uio_in[UIO_OSEL] ? rem_q : quo_q;
    uio_out           = '0;
    uio_out[UIO_BUSY] = (state_q == S_RUN);
    uio_out[UIO_DONE] = (state_q == S_DONE);
    uio_out[UIO_DBZ]  = dbz_q;
    uio_oe            = UIO_OE_VAL;
  end

endmodule

// File: tb/tb_tt_um_ashergitscrazy_divider.sv
// Scoreboard bench for the divider: expected results are queued at start and
// checked, with latency and busy length, when done rises.
module tb_tt_um_ashergitscrazy_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic       start = 1'b0, load = 1'b0, lsel = 1'b0, osel = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign uio_in = {4'b0000, osel, lsel, load, start};

  tt_um_ashergitscrazy_divider #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
    int         busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0, busy_cyc = 0, busy_rise = 0;
  int t0 = 0, b0 = 0, rise0 = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc++;

  // Busy-length and busy-pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (uio_out[4]) busy_cyc++;
    if (uio_out[4] && !busy_prev) busy_rise++;
    busy_prev = uio_out[4];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic sel, input logic [7:0] v);
    ui_in = v; lsel = sel; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start(input logic hold);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    t0 = cyc;
    b0 = busy_cyc;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input int lat, input int busy, input logic hold);
    exp_t e;
    e.dbz  = (b == 8'd0);
    e.q    = e.dbz ? 8'hFF : a / b;
    e.r    = e.dbz ? a : a % b;
    e.lat  = lat;
    e.busy = busy;
    sb.push_back(e);
    pulse_start(hold);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!uio_out[5] && n < 60);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc - t0, e.lat);
      chk({tag, "_busy_cycles"}, busy_cyc - b0, e.busy);
      chk({tag, "_dbz"}, {31'd0, uio_out[6]}, {31'd0, e.dbz});
      osel = 1'b0; #1;
      chk({tag, "_quotient"}, {24'd0, uo_out}, {24'd0, e.q});
      osel = 1'b1; #1;
      chk({tag, "_remainder"}, {24'd0, uo_out}, {24'd0, e.r});
      osel = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_uio_oe", {24'd0, uio_oe}, 32'hF0);
    chk("rst_uo_out", {24'd0, uo_out}, 32'd0);
    chk("rst_uio_out", {24'd0, uio_out}, 32'd0);
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_status", {24'd0, uio_out}, 32'd0);

    // 200 / 7
    load_op(1'b0, 8'd200);
    load_op(1'b1, 8'd7);
    start_op(8'd200, 8'd7, 9, 8, 1'b0);
    wait_done("div200_7");
    chk("div200_7_fixed_bits", {24'd0, uio_out & 8'h8F}, 32'd0);

    // 13 / 0 from DONE
    load_op(1'b0, 8'd13);
    load_op(1'b1, 8'd0);
    start_op(8'd13, 8'd0, 1, 0, 1'b0);
    wait_done("div13_0");

    // Held start: exactly one operation
    load_op(1'b0, 8'd255);
    load_op(1'b1, 8'd255);
    rise0 = busy_rise;
    start_op(8'd255, 8'd255, 9, 8, 1'b1);
    wait_done("held255");
    repeat (10) tick();
    start = 1'b0;
    chk("held_busy_pulses", busy_rise - rise0, 32'd1);
    chk("held_still_done", {31'd0, uio_out[5]}, 32'd1);
    chk("held_not_busy", {31'd0, uio_out[4]}, 32'd0);

    // Load during RUN is ignored
    load_op(1'b0, 8'd100);
    load_op(1'b1, 8'd10);
    start_op(8'd100, 8'd10, 9, 8, 1'b0);
    tick();
    load_op(1'b0, 8'd99);
    wait_done("div100_10");
    // Load in DONE leaves results and done alone
    load_op(1'b0, 8'd99);
    chk("load_in_done_done", {31'd0, uio_out[5]}, 32'd1);
    chk("load_in_done_quo", {24'd0, uo_out}, 32'd10);
    start_op(8'd99, 8'd10, 9, 8, 1'b0);
    wait_done("div99_10");

    // Reset mid-RUN
    load_op(1'b0, 8'd100);
    load_op(1'b1, 8'd7);
    pulse_start(1'b0);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_uio_out", {24'd0, uio_out}, 32'd0);
    chk("midrst_quo", {24'd0, uo_out}, 32'd0);
    osel = 1'b1; #1;
    chk("midrst_rem", {24'd0, uo_out}, 32'd0);
    osel = 1'b0;
    chk("midrst_uio_oe", {24'd0, uio_oe}, 32'hF0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("postrst_done", {31'd0, uio_out[5]}, 32'd0);
    chk("postrst_uo_out", {24'd0, uo_out}, 32'd0);
    load_op(1'b0, 8'd50);
    load_op(1'b1, 8'd3);
    start_op(8'd50, 8'd3, 9, 8, 1'b0);
    wait_done("div50_3");

    // ena low for 5 cycles mid-RUN
    load_op(1'b0, 8'd17);
    load_op(1'b1, 8'd5);
    start_op(8'd17, 8'd5, 14, 13, 1'b0);
    repeat (3) tick();
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    wait_done("div17_5_stall");

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
